// File: rtl/result_bcd_display_if.sv
// Handshake and result bundle between the adder-side requester and the BCD display converter.
interface result_bcd_display_if #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
);
  logic                  i_start;
  logic [WIDTH-1:0]      i_bin;
  logic                  o_busy;
  logic                  o_valid;
  logic [4*DIGITS-1:0]   o_bcd;
  logic [7*DIGITS-1:0]   o_seg;
  logic                  o_ovf;

  modport master (
    output i_start, i_bin,
    input  o_busy, o_valid, o_bcd, o_seg, o_ovf
  );

  modport slave (
    input  i_start, i_bin,
    output o_busy, o_valid, o_bcd, o_seg, o_ovf
  );
endinterface

// File: rtl/result_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// active-low seven-segment decode and overflow flag for values beyond the digit count.
module result_bcd_display #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  result_bcd_display_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  bin_reg, bin_next;
  logic [BW-1:0]     bcd_reg, bcd_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              sticky_reg, sticky_next;
  logic              busy_reg, busy_next;
  logic              valid_reg, valid_next;
  logic [BW-1:0]     bcd_out_reg, bcd_out_next;
  logic [SW-1:0]     seg_reg, seg_next;
  logic              ovf_reg, ovf_next;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     shifted;
  logic [SW-1:0]     seg_dec;
  logic              shift_out;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction is per digit; no carry crosses a digit boundary.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      assign d                  = bcd_reg[4*gi +: 4];
      assign adj[4*gi +: 4]     = (d >= 4'd5) ? d + 4'd3 : d;
      assign seg_dec[7*gi +: 7] = seg_of(shifted[4*gi +: 4]);
    end
  endgenerate

  assign shifted   = {adj[BW-2:0], bin_reg[WIDTH-1]};
  assign shift_out = adj[BW-1];

  always_comb begin
    state_next   = state_reg;
    bin_next     = bin_reg;
    bcd_next     = bcd_reg;
    cnt_next     = cnt_reg;
    sticky_next  = sticky_reg;
    valid_next   = 1'b0;
    bcd_out_next = bcd_out_reg;
    seg_next     = seg_reg;
    ovf_next     = ovf_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.i_start) begin
          bin_next    = bus.i_bin;
          bcd_next    = '0;
          sticky_next = 1'b0;
          cnt_next    = CW'(WIDTH);
          state_next  = SHIFT;
        end else begin
          state_next  = IDLE;
        end
      end
      SHIFT: begin
        bcd_next    = shifted;
        bin_next    = bin_reg << 1;
        sticky_next = sticky_reg | shift_out;
        cnt_next    = cnt_reg - CW'(1);
        // The last shift publishes straight into the output registers so the
        // result is visible in the same cycle as the valid pulse.
        if (cnt_reg == CW'(1)) begin
          state_next   = DONE;
          bcd_out_next = shifted;
          seg_next     = seg_dec;
          ovf_next     = sticky_reg | shift_out;
          valid_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == SHIFT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      bcd_reg     <= '0;
      cnt_reg     <= '0;
      sticky_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      bcd_out_reg <= '0;
      seg_reg     <= {DIGITS{7'b1000000}};
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bin_reg     <= bin_next;
      bcd_reg     <= bcd_next;
      cnt_reg     <= cnt_next;
      sticky_reg  <= sticky_next;
      busy_reg    <= busy_next;
      valid_reg   <= valid_next;
      bcd_out_reg <= bcd_out_next;
      seg_reg     <= seg_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign bus.o_busy  = busy_reg;
  assign bus.o_valid = valid_reg;
  assign bus.o_bcd   = bcd_out_reg;
  assign bus.o_seg   = seg_reg;
  assign bus.o_ovf   = ovf_reg;
endmodule
